// File: rtl/ce_pcie_tx_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ce_pcie_tx_arb_if
// Purpose  : AXI-Stream bundle of LANES parallel streams. Lane i's fields
//            sit at slice i of each flattened vector.
// Modports : master - drives tvalid/tdata/tkeep/tuser/tlast, samples tready
//            slave  - samples tvalid/tdata/tkeep/tuser/tlast, drives tready
// Revision : 1.0  initial release
// ============================================================================
interface ce_pcie_tx_arb_if #(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 512,
  parameter int USER_WIDTH = 10
);
  logic [LANES-1:0]              tvalid;
  logic [LANES-1:0]              tready;
  logic [LANES*DATA_WIDTH-1:0]   tdata;
  logic [LANES*DATA_WIDTH/8-1:0] tkeep;
  logic [LANES*USER_WIDTH-1:0]   tuser;
  logic [LANES-1:0]              tlast;

  modport master (output tvalid, tdata, tkeep, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/ce_pcie_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : ce_pcie_tx_arb
// Purpose  : Packet-level round-robin arbiter sharing the PCIe TX AXI-Stream
//            between NUM_PORTS sources. The grant is held for a whole packet;
//            a 2-entry output buffer decouples source tready from sink tready.
//            Per-port packet counters and a packet-length watchdog feed
//            debug CSRs.
// Ports    : fim_clk, fim_rst_n    clock, synchronous active-low reset
//            s (slave)             NUM_PORTS source streams
//            m (master)            single sink stream
//            busy                  grant held (LOCKED)
//            grant_port            current / last granted port
//            pkt_cnt               packets forwarded, CNT_WIDTH per port
//            err_pkt_len           sticky: packet exceeded MAX_PKT_BEATS
// Revision : 1.0  initial release
// ============================================================================
module ce_pcie_tx_arb #(
  parameter int NUM_PORTS     = 2,
  parameter int DATA_WIDTH    = 512,
  parameter int USER_WIDTH    = 10,
  parameter int MAX_PKT_BEATS = 64,
  parameter int CNT_WIDTH     = 16,
  localparam int PORT_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                           fim_clk,
  input  logic                           fim_rst_n,
  ce_pcie_tx_arb_if.slave                s,
  ce_pcie_tx_arb_if.master               m,
  output logic                           busy,
  output logic [PORT_W-1:0]              grant_port,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_cnt,
  output logic                           err_pkt_len
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int ENT_W  = DATA_WIDTH + KEEP_W + USER_WIDTH + 1;
  localparam int BEAT_W = $clog2(MAX_PKT_BEATS + 2);
  localparam logic [BEAT_W-1:0] C_BEAT_SAT = BEAT_W'(MAX_PKT_BEATS + 1);
  localparam logic [BEAT_W-1:0] C_BEAT_MAX = BEAT_W'(MAX_PKT_BEATS);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Registered state
  state_t               state_q, state_d;
  logic [PORT_W-1:0]    rr_q, rr_d;
  logic [PORT_W-1:0]    grant_q, grant_d;
  logic [1:0]           occ_q, occ_d;
  logic                 wr_q, wr_d;
  logic                 rd_q, rd_d;
  logic [ENT_W-1:0]     buf_q [2];
  logic [ENT_W-1:0]     buf_d [2];
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_PORTS];
  logic                 err_q, err_d;

  // Combinational helpers
  logic [NUM_PORTS-1:0] w_s_ready;
  logic                 w_push;
  logic                 w_pop;
  logic [ENT_W-1:0]     w_entry;
  logic                 w_last;
  logic [BEAT_W-1:0]    w_beat_inc;
  logic                 w_found;
  logic [PORT_W-1:0]    w_pick;
  int                   w_idx;

  // Beat fields of the granted source, packed in buffer-entry order.
  always_comb begin
    w_entry = {s.tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH],
               s.tkeep[int'(grant_q)*KEEP_W +: KEEP_W],
               s.tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH],
               s.tlast[grant_q]};
    w_last  = s.tlast[grant_q];
  end

  // tready depends only on registered state so it never combinationally
  // follows the sink's tready.
  always_comb begin
    w_s_ready = '0;
    if (state_q == ST_LOCKED && occ_q != 2'd2) begin
      w_s_ready[grant_q] = 1'b1;
    end
  end

  assign w_push = w_s_ready[grant_q] & s.tvalid[grant_q];
  assign w_pop  = (occ_q != 2'd0) & m.tready[0];

  // Beat counter saturates one past the limit so it cannot wrap on runaway
  // packets.
  assign w_beat_inc = (beat_q == C_BEAT_SAT) ? beat_q : beat_q + 1'b1;

  // Round-robin scan upward from rr_q, wrapping at NUM_PORTS.
  always_comb begin
    w_found = 1'b0;
    w_pick  = rr_q;
    w_idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = int'(rr_q) + i;
      if (w_idx >= NUM_PORTS) begin
        w_idx = w_idx - NUM_PORTS;
      end
      if (!w_found && s.tvalid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = PORT_W'(w_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    occ_d   = occ_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    buf_d   = buf_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          grant_d = w_pick;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_push) begin
          if (w_last) begin
            state_d        = ST_IDLE;
            rr_d           = (int'(grant_q) == NUM_PORTS - 1) ? '0 : grant_q + 1'b1;
            cnt_d[grant_q] = cnt_q[grant_q] + 1'b1;
            beat_d         = '0;
          end else begin
            beat_d = w_beat_inc;
            if (w_beat_inc == C_BEAT_MAX) begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_push) begin
      buf_d[wr_q] = w_entry;
      wr_d        = ~wr_q;
    end
    if (w_pop) begin
      rd_d = ~rd_q;
    end
    occ_d = occ_q + 2'(w_push) - 2'(w_pop);
  end

  always_ff @(posedge fim_clk) begin
    if (!fim_rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      occ_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      occ_q   <= occ_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s.tready    = w_s_ready;
  assign m.tvalid[0] = (occ_q != 2'd0);
  assign {m.tdata, m.tkeep, m.tuser, m.tlast} = buf_q[rd_q];

  assign busy        = (state_q == ST_LOCKED);
  assign grant_port  = grant_q;
  assign err_pkt_len = err_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

endmodule
`default_nettype wire
